// File: rtl/base2_pow_compose_if.sv
// base2_pow_compose_if: valid/ready token bus for the 2^(k+f) composer.
// master drives k/f and the output ready; slave is the composer itself.
interface base2_pow_compose_if #(
  parameter int DW = 16
);
  logic          valid_i;
  logic          ready_o;
  logic [7:0]    k_i;
  logic [DW-1:0] f_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] y_o;
  logic          ovf_o;
  logic          unf_o;

  modport master (
    output valid_i,
    output k_i,
    output f_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  y_o,
    input  ovf_o,
    input  unf_o
  );

  modport slave (
    input  valid_i,
    input  k_i,
    input  f_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output y_o,
    output ovf_o,
    output unf_o
  );
endinterface

// File: rtl/base2_pow_compose.sv
// base2_pow_compose: FP16 2^(k+f) from k and f, 2^f by 16-segment PWL.
// Three-stage pipe under one global enable; synchronous reset.
module base2_pow_compose #(
  parameter int FW       = 12,
  parameter int SEG_BITS = 4,
  parameter int DW       = 16
) (
  input logic clk,
  input logic rst,
  base2_pow_compose_if.slave bus
);
  localparam int NSEG = 1 << SEG_BITS;
  localparam int RW   = FW - SEG_BITS;
  localparam int CW   = FW + 2;
  localparam int PW   = CW + RW;

  typedef logic [CW-1:0] coef_t;
  typedef logic [NSEG:0][CW-1:0] rom_t;

  typedef struct packed {
    logic          v;
    logic [7:0]    k;
    logic [FW-1:0] u;
  } s1_t;

  typedef struct packed {
    logic        v;
    logic [7:0]  k;
    logic [FW:0] p;
  } s2_t;

  // Segment base points 2^(i/NSEG) in Q1.FW, plus the 2.0 end point.
  function automatic rom_t c0_rom();
    rom_t t;
    real  v;
    t = '0;
    for (int i = 0; i < NSEG; i++) begin
      v = (2.0 ** (real'(i) / real'(NSEG))) * (2.0 ** FW);
      t[i] = coef_t'($rtoi(v + 0.5));
    end
    t[NSEG] = coef_t'(1) << (FW + 1);
    return t;
  endfunction

  localparam rom_t        C0   = c0_rom();
  localparam logic [CW:0] PLIM = (CW+1)'(1) << (FW + 1);
  localparam logic [FW:0] PMAX = '1;

  logic en;
  assign en = bus.ready_i | ~bus.valid_o;
  assign bus.ready_o = en;

  logic          sgn;
  logic [4:0]    ex;
  logic [9:0]    man;
  logic [4:0]    sh;
  logic [FW+10:0] wide;
  logic [FW+10:0] shr;
  logic [FW-1:0] u_n;

  assign sgn = bus.f_i[15];
  assign ex  = bus.f_i[14:10];
  assign man = bus.f_i[9:0];

  // FP16 f to Q0.FW; negatives and tiny values go to 0, f>=1 saturates.
  always_comb begin
    wide = {1'b1, man, {FW{1'b0}}};
    sh   = 5'd25 - ex;
    shr  = wide >> sh;
    u_n  = '0;
    unique case (1'b1)
      (sgn | (ex == 5'd0)):    u_n = '0;
      (~sgn & (ex >= 5'd15)):  u_n = '1;
      default:                 u_n = shr[FW-1:0];
    endcase
  end

  s1_t s1;

  // Stage 1 register: fixed-point fraction and k.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else if (en) begin
      s1 <= '{v: bus.valid_i, k: bus.k_i, u: u_n};
    end
  end

  logic [SEG_BITS-1:0] idx;
  logic [SEG_BITS:0]   idx1;
  logic [RW-1:0]       r;
  coef_t               c0;
  coef_t               c1;
  logic [PW-1:0]       prod;
  logic [CW:0]         p_sum;
  logic [FW:0]         p_n;

  // PWL: base point plus slope times in-segment offset, clamped below 2.0.
  always_comb begin
    idx   = s1.u[FW-1 -: SEG_BITS];
    idx1  = {1'b0, idx} + (SEG_BITS+1)'(1);
    r     = s1.u[RW-1:0];
    c0    = C0[{1'b0, idx}];
    c1    = C0[idx1] - c0;
    prod  = PW'(c1) * PW'(r);
    p_sum = {1'b0, c0} + (CW+1)'(prod >> RW);
    p_n   = (p_sum >= PLIM) ? PMAX : p_sum[FW:0];
  end

  s2_t s2;

  // Stage 2 register: 2^f in Q1.FW and k.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
    end else if (en) begin
      s2 <= '{v: s1.v, k: s1.k, p: p_n};
    end
  end

  logic signed [8:0] e;
  logic              ovf_n;
  logic              unf_n;
  logic [DW-1:0]     y_n;

  // Compose: biased k into the exponent, saturate or flush at the ends.
  always_comb begin
    e     = $signed({s2.k[7], s2.k}) + 9'sd15;
    ovf_n = (e >= 9'sd31);
    unf_n = (e <= 9'sd0);
    y_n   = '0;
    unique case (1'b1)
      ovf_n:   y_n = DW'(16'h7C00);
      unf_n:   y_n = '0;
      default: y_n = DW'({1'b0, e[4:0], s2.p[FW-1 -: 10]});
    endcase
  end

  // Output register; bubbles leave y and flags at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid_o <= 1'b0;
      bus.y_o     <= '0;
      bus.ovf_o   <= 1'b0;
      bus.unf_o   <= 1'b0;
    end else if (en) begin
      bus.valid_o <= s2.v;
      bus.y_o     <= s2.v ? y_n : '0;
      bus.ovf_o   <= s2.v & ovf_n;
      bus.unf_o   <= s2.v & unf_n;
    end
  end

  logic unused;
  assign unused = ^{shr, p_sum, bus.f_i};
endmodule

// File: tb/tb_base2_pow_compose.sv
// tb_base2_pow_compose: directed table, stall/reset sequences and
// random traffic checked against an arithmetic model and scoreboard.
module tb_base2_pow_compose;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  base2_pow_compose_if #(.DW(16)) bus ();

  base2_pow_compose #(
    .FW(12),
    .SEG_BITS(4),
    .DW(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic signed [7:0] k;
    logic [15:0]       f;
    logic [15:0]       y;
    logic              ovf;
    logic              unf;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic        ovf;
    logic        unf;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  bit   held = 1'b0;
  logic [15:0] hy;
  logic hov;
  logic hun;
  logic [15:0] cur_y;
  logic cur_ovf;
  logic cur_unf;

  int c0_tab[17] = '{4096, 4277, 4467, 4664, 4871, 5087, 5312, 5547,
                     5793, 6049, 6317, 6597, 6889, 7194, 7512, 7845, 8192};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // 2^(k+f): f floored to 1/4096, PWL between 2^(i/16) points, FP16 pack.
  task automatic model(input logic signed [7:0] k, input logic [15:0] f,
                       output logic [15:0] y, output logic ovf,
                       output logic unf);
    int ex;
    int u;
    int idx;
    int r;
    int p;
    int e;
    longint num;
    ex = int'(f[14:10]);
    if (f[15] || ex == 0) u = 0;
    else if (ex >= 15) u = 4095;
    else begin
      num = longint'(1024 + int'(f[9:0])) * 4096;
      u = int'(num / (longint'(1) << (25 - ex)));
    end
    idx = u / 256;
    r = u % 256;
    p = c0_tab[idx] + ((c0_tab[idx+1] - c0_tab[idx]) * r) / 256;
    if (p >= 8192) p = 8191;
    e = int'(k) + 15;
    ovf = 1'b0;
    unf = 1'b0;
    if (e >= 31) begin
      y = 16'h7C00;
      ovf = 1'b1;
    end else if (e <= 0) begin
      y = 16'h0000;
      unf = 1'b1;
    end else begin
      y = 16'((e << 10) | ((p - 4096) / 4));
    end
  endtask

  // Scoreboard: push on acceptance, pop and compare on output transfer.
  always @(negedge clk) begin
    exp_t ex;
    cyc++;
    if (rst) begin
      sbq.delete();
      held = 1'b0;
    end else begin
      chk("ready_o", 32'(bus.ready_o), 32'(1'(bus.ready_i | ~bus.valid_o)));
      if (held) begin
        chk("stall_valid", 32'(bus.valid_o), 32'd1);
        chk("stall_y", 32'(bus.y_o), 32'(hy));
        chk("stall_flags", 32'({bus.ovf_o, bus.unf_o}), 32'({hov, hun}));
      end
      held = bus.valid_o & ~bus.ready_i;
      hy = bus.y_o;
      hov = bus.ovf_o;
      hun = bus.unf_o;
      if (bus.valid_o && bus.ready_i) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h required=none", bus.y_o);
        end else begin
          ex = sbq.pop_front();
          chk("y", 32'(bus.y_o), 32'(ex.y));
          chk("ovf", 32'(bus.ovf_o), 32'(ex.ovf));
          chk("unf", 32'(bus.unf_o), 32'(ex.unf));
          if (lat_chk) chk("latency", 32'(cyc - ex.acc), 32'd3);
        end
      end
      if (bus.valid_i && bus.ready_o)
        sbq.push_back('{y: cur_y, ovf: cur_ovf, unf: cur_unf, acc: cyc});
    end
  end

  task automatic put_rand();
    logic signed [7:0] k;
    logic [15:0] f;
    if ($urandom_range(0, 9) == 0) k = 8'($urandom);
    else k = 8'(int'($urandom_range(0, 40)) - 20);
    if ($urandom_range(0, 9) == 0) f = 16'($urandom);
    else f = {1'b0, 5'($urandom_range(0, 14)), 10'($urandom)};
    bus.k_i = k;
    bus.f_i = f;
    model(k, f, cur_y, cur_ovf, cur_unf);
  endtask

  task automatic put_vec(input vec_t v);
    bus.k_i = v.k;
    bus.f_i = v.f;
    cur_y = v.y;
    cur_ovf = v.ovf;
    cur_unf = v.unf;
  endtask

  task automatic wait_empty(input int n);
    for (int c = 0; c < n && sbq.size() != 0; c++) @(negedge clk);
    #1;
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  vec_t tbl[16];
  bit   acc;

  initial begin
    tbl[0]  = '{8'sd0,   16'h0000, 16'h3C00, 1'b0, 1'b0};
    tbl[1]  = '{8'sd3,   16'h3800, 16'h49A8, 1'b0, 1'b0};
    tbl[2]  = '{-8'sd1,  16'h0000, 16'h3800, 1'b0, 1'b0};
    tbl[3]  = '{8'sd16,  16'h0000, 16'h7C00, 1'b1, 1'b0};
    tbl[4]  = '{-8'sd15, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[5]  = '{-8'sd14, 16'h0000, 16'h0400, 1'b0, 1'b0};
    tbl[6]  = '{8'sd0,   16'h3C00, 16'h3FFF, 1'b0, 1'b0};
    tbl[7]  = '{8'sd2,   16'h8000, 16'h4400, 1'b0, 1'b0};
    tbl[8]  = '{8'sd0,   16'h7C00, 16'h3FFF, 1'b0, 1'b0};
    tbl[9]  = '{8'sd1,   16'h0001, 16'h4000, 1'b0, 1'b0};
    tbl[10] = '{8'sd15,  16'h0000, 16'h7800, 1'b0, 1'b0};
    tbl[11] = '{8'h80,   16'h3800, 16'h0000, 1'b0, 1'b1};
    tbl[12] = '{8'sd127, 16'h0000, 16'h7C00, 1'b1, 1'b0};
    tbl[13] = '{8'sd0,   16'h3400, 16'h3CC1, 1'b0, 1'b0};
    tbl[14] = '{-8'sd2,  16'h3A00, 16'h36BA, 1'b0, 1'b0};
    tbl[15] = '{8'sd0,   16'h3555, 16'h3D0A, 1'b0, 1'b0};

    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.k_i = '0;
    bus.f_i = '0;
    bus.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(bus.valid_o), 32'd0);
    chk("reset_y", 32'(bus.y_o), 32'd0);
    chk("reset_flags", 32'({bus.ovf_o, bus.unf_o}), 32'd0);

    // One token at a time, fixed latency.
    lat_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 bus.valid_i = 1'b1;
      put_vec(tbl[i]);
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      wait_empty(10);
    end

    // Same table at full rate.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 bus.valid_i = 1'b1;
      put_vec(tbl[i]);
    end
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    wait_empty(20);

    // Six tokens, output stalled four cycles mid-stream.
    lat_chk = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1 bus.valid_i = 1'b1;
      put_rand();
    end
    @(posedge clk);
    #1 put_rand();
    bus.ready_i = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("bp_ready_o", 32'(bus.ready_o), 32'd0);
      chk("bp_valid_o", 32'(bus.valid_o), 32'd1);
    end
    @(posedge clk);
    #1 bus.ready_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("bp_rate", 32'(bus.valid_o), 32'd1);
      @(posedge clk);
      #1;
      if (j < 2) put_rand();
      else bus.valid_i = 1'b0;
    end
    wait_empty(20);

    // Reset with three tokens in flight.
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1 bus.valid_i = 1'b1;
      put_rand();
    end
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_y", 32'(bus.y_o), 32'd0);
    chk("rst_flags", 32'({bus.ovf_o, bus.unf_o}), 32'd0);

    // Reset while the output is stalled.
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1 bus.valid_i = 1'b1;
      put_rand();
    end
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("rst_stall_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_stall_y", 32'(bus.y_o), 32'd0);

    // Token after reset appears with normal latency.
    lat_chk = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b1;
    put_rand();
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    wait_empty(10);

    // Random traffic with random backpressure; held tokens stay put.
    lat_chk = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = bus.valid_i & bus.ready_o;
      @(posedge clk);
      #1;
      if (!bus.valid_i || acc) begin
        bus.valid_i = ($urandom_range(0, 3) != 0);
        if (bus.valid_i) put_rand();
      end
      bus.ready_i = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    acc = bus.valid_i & bus.ready_o;
    while (bus.valid_i && !acc) begin
      @(negedge clk);
      acc = bus.valid_i & bus.ready_o;
    end
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    wait_empty(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
